// File: rtl/rw_window_pkg.sv
// rw_window_pkg: shared types and constants for the write/read window responder.
//   state_t    responder FSM states
//   DATA_W_DEF default captured word width
//   DEPTH_DEF  default buffer depth (power of 2, >= 2)
//   missSat()  saturation value of a frame statistic counter of a given width
package rw_window_pkg;

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 32;

    function automatic int missSat(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/rw_window_mem.sv
// rw_window_mem: simple dual-port buffer RAM, synchronous write, registered read.
//   clk    clock, posedge
//   rst    asynchronous active-low reset (read register only; storage is not reset)
//   we     write enable;  wAddr/wData  write address and word
//   re     read enable;   rAddr        read address
//   rData  registered read word, holds between reads
module rw_window_mem
    import rw_window_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wAddr,
    input  logic [DATA_W-1:0] wData,
    input  logic              re,
    input  logic [ADDR_W-1:0] rAddr,
    output logic [DATA_W-1:0] rData
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[wAddr] <= wData;

    always_ff @(posedge clk or negedge rst)
        if (!rst) rData <= '0;
        else if (re) rData <= mem[rAddr];

endmodule

// File: rtl/rw_window_responder.sv
// rw_window_responder: captures words during the write window and drains them in order during the read window.
//   clk         clock, posedge
//   rst         asynchronous active-low reset
//   txWr/txRd   write / read window levels
//   wrData      word captured on write cycles
//   rdData      drained word, valid when rdValid
//   frameDone   one-cycle pulse after the read window closes
//   frameWrLen  words accepted in the last frame
//   frameRdLen  words drained in the last frame
//   frameMiss   read cycles that found the buffer empty (saturating)
//   overflow    sticky, a write was dropped on a full buffer
//   windowErr   sticky, both windows were high together
module rw_window_responder
    import rw_window_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              txWr,
    input  logic              txRd,
    input  logic [DATA_W-1:0] wrData,
    output logic [DATA_W-1:0] rdData,
    output logic              rdValid,
    output logic              frameDone,
    output logic [ADDR_W:0]   frameWrLen,
    output logic [ADDR_W:0]   frameRdLen,
    output logic [ADDR_W:0]   frameMiss,
    output logic              overflow,
    output logic              windowErr
);

    localparam logic [ADDR_W:0] FULL     = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] MISS_SAT = (ADDR_W+1)'(missSat(ADDR_W + 1));

    state_t            state;
    logic [ADDR_W-1:0] wrPtr, rdPtr;
    logic [ADDR_W:0]   count, wrCnt, rdCnt, missCnt;
    logic              both, wrCyc, rdCyc, doWr, doRd, frameEnd;

    assign both     = txWr & txRd;
    assign wrCyc    = txWr & ~txRd & (state != READ);
    assign rdCyc    = txRd & ~txWr & (state != WRITE);
    assign doWr     = wrCyc & (count != FULL);
    assign doRd     = rdCyc & (count != '0);
    // The frame ends on the first sample of a closed read window while in READ.
    assign frameEnd = (state == READ) & ~txRd;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state      <= IDLE;
            wrPtr      <= '0;
            rdPtr      <= '0;
            count      <= '0;
            wrCnt      <= '0;
            rdCnt      <= '0;
            missCnt    <= '0;
            rdValid    <= 1'b0;
            frameDone  <= 1'b0;
            frameWrLen <= '0;
            frameRdLen <= '0;
            frameMiss  <= '0;
            overflow   <= 1'b0;
            windowErr  <= 1'b0;
        end else begin
            rdValid   <= doRd;
            frameDone <= frameEnd;
            if (both) windowErr <= 1'b1;
            if (wrCyc && !doWr) overflow <= 1'b1;
            if (frameEnd) begin
                frameWrLen <= wrCnt;
                frameRdLen <= rdCnt;
                frameMiss  <= missCnt;
                wrPtr      <= '0;
                rdPtr      <= '0;
                count      <= '0;
                wrCnt      <= '0;
                rdCnt      <= '0;
                missCnt    <= '0;
            end else begin
                if (doWr) begin
                    wrPtr <= wrPtr + 1'b1;
                    count <= count + 1'b1;
                    wrCnt <= wrCnt + 1'b1;
                end
                if (doRd) begin
                    rdPtr <= rdPtr + 1'b1;
                    count <= count - 1'b1;
                    rdCnt <= rdCnt + 1'b1;
                end
                if (rdCyc && !doRd && missCnt != MISS_SAT) missCnt <= missCnt + 1'b1;
            end
            state <= both            ? IDLE :
                     (state == IDLE)  ? (txWr ? WRITE : txRd ? READ : IDLE) :
                     (state == WRITE) ? (txWr ? WRITE : IDLE) :
                                        (txRd ? READ : IDLE);
        end

    rw_window_mem #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) uMem (
        .clk  (clk),
        .rst  (rst),
        .we   (doWr),
        .wAddr(wrPtr),
        .wData(wrData),
        .re   (doRd),
        .rAddr(rdPtr),
        .rData(rdData)
    );

endmodule

// File: tb/tb_rw_window_responder.sv
// tb_rw_window_responder: frame-level scoreboard bench for rw_window_responder.
module tb_rw_window_responder;

    localparam int DEPTH = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       txWr, txRd;
    logic [7:0] wrData, rdData;
    logic       rdValid, frameDone, overflow, windowErr;
    logic [5:0] frameWrLen, frameRdLen, frameMiss;

    int checks = 0;
    int errors = 0;
    bit expOvf = 0;
    bit expErr = 0;

    logic [31:0] eData[$], oData[$], eWr[$], oWr[$], eRd[$], oRd[$], eMiss[$], oMiss[$];
    longint      eTime[$], oTime[$], eDoneT[$], oDoneT[$];

    rw_window_responder dut (
        .clk       (clk),
        .rst       (rst),
        .txWr      (txWr),
        .txRd      (txRd),
        .wrData    (wrData),
        .rdData    (rdData),
        .rdValid   (rdValid),
        .frameDone (frameDone),
        .frameWrLen(frameWrLen),
        .frameRdLen(frameRdLen),
        .frameMiss (frameMiss),
        .overflow  (overflow),
        .windowErr (windowErr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rdValid) begin
            oData.push_back(32'(rdData));
            oTime.push_back(longint'($time));
        end
        if (frameDone) begin
            oWr.push_back(32'(frameWrLen));
            oRd.push_back(32'(frameRdLen));
            oMiss.push_back(32'(frameMiss));
            oDoneT.push_back(longint'($time));
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic w, input logic r, input logic [7:0] d);
        @(negedge clk);
        txWr   = w;
        txRd   = r;
        wrData = d;
    endtask

    task automatic chkZero();
        chk("rst_rdData", 64'(rdData), 0);
        chk("rst_rdValid", 64'(rdValid), 0);
        chk("rst_frameDone", 64'(frameDone), 0);
        chk("rst_frameWrLen", 64'(frameWrLen), 0);
        chk("rst_frameRdLen", 64'(frameRdLen), 0);
        chk("rst_frameMiss", 64'(frameMiss), 0);
        chk("rst_overflow", 64'(overflow), 0);
        chk("rst_windowErr", 64'(windowErr), 0);
    endtask

    // One frame: w write-window cycles, gap idle cycles, r read-window cycles, post idle cycles.
    // With ovl the read window opens on the last write-window cycle instead of after a gap.
    // Expectations follow from the buffer rules: the first min(w,DEPTH) words are accepted,
    // the read window drains as many as it can from its first cycle, the rest are misses.
    task automatic frame(input int w, input int gap, input int r, input int post, input bit rnd, input bit ovl);
        logic [7:0] sent[$];
        logic [7:0] d;
        int nw, acc, rl, ms;
        longint tr, tEnd;
        nw = ovl ? w - 1 : w;
        tr = 0;
        for (int i = 0; i < nw; i++) begin
            d = rnd ? 8'($urandom) : 8'(i);
            cycle(1'b1, 1'b0, d);
            sent.push_back(d);
        end
        if (ovl) begin
            cycle(1'b1, 1'b1, 8'($urandom));
            expErr = 1;
        end else
            repeat (gap) cycle(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < r; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            if (i == 0) tr = longint'($time);
        end
        cycle(1'b0, 1'b0, 8'h00);
        tEnd = longint'($time);
        repeat (post - 1) cycle(1'b0, 1'b0, 8'h00);
        acc = nw < DEPTH ? nw : DEPTH;
        if (nw > DEPTH) expOvf = 1;
        rl = acc < r ? acc : r;
        ms = r - rl;
        if (ms > 63) ms = 63;
        for (int i = 0; i < rl; i++) begin
            eData.push_back(32'(sent[i]));
            eTime.push_back(tr + 10 * (i + 1));
        end
        eWr.push_back(32'(acc));
        eRd.push_back(32'(rl));
        eMiss.push_back(32'(ms));
        eDoneT.push_back(tEnd + 10);
    endtask

    task automatic settle(input string tag);
        int n;
        repeat (3) cycle(1'b0, 1'b0, 8'h00);
        #1;
        chk({tag, "_nData"}, 64'(oData.size()), 64'(eData.size()));
        n = oData.size() < eData.size() ? oData.size() : eData.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_data"}, 64'(oData[i]), 64'(eData[i]));
            chk({tag, "_dataTime"}, 64'(oTime[i]), 64'(eTime[i]));
        end
        chk({tag, "_nDone"}, 64'(oWr.size()), 64'(eWr.size()));
        n = oWr.size() < eWr.size() ? oWr.size() : eWr.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_frameWrLen"}, 64'(oWr[i]), 64'(eWr[i]));
            chk({tag, "_frameRdLen"}, 64'(oRd[i]), 64'(eRd[i]));
            chk({tag, "_frameMiss"}, 64'(oMiss[i]), 64'(eMiss[i]));
            chk({tag, "_doneTime"}, 64'(oDoneT[i]), 64'(eDoneT[i]));
        end
        if (eWr.size() > 0) chk({tag, "_holdWrLen"}, 64'(frameWrLen), 64'(eWr[$]));
        chk({tag, "_overflow"}, 64'(overflow), 64'(expOvf));
        chk({tag, "_windowErr"}, 64'(windowErr), 64'(expErr));
        eData.delete(); oData.delete(); eTime.delete(); oTime.delete();
        eWr.delete(); oWr.delete(); eRd.delete(); oRd.delete();
        eMiss.delete(); oMiss.delete(); eDoneT.delete(); oDoneT.delete();
    endtask

    initial begin
        rst = 1'b0;
        txWr = 1'b0;
        txRd = 1'b0;
        wrData = 8'h00;
        #12;
        chkZero();
        @(negedge clk);
        rst = 1'b1;

        frame(0, 1, 5, 1, 1'b0, 1'b0);
        settle("readOnly");

        frame(20, 15, 25, 1, 1'b0, 1'b0);
        settle("nominal");

        frame(7, 2, 7, 1, 1'b1, 1'b0);
        frame(5, 1, 9, 1, 1'b1, 1'b0);
        settle("backToBack");

        frame(2, 1, 70, 1, 1'b1, 1'b0);
        settle("missSat");

        for (int k = 0; k < 5; k++) begin
            frame($urandom_range(1, 32), $urandom_range(1, 4), $urandom_range(1, 40),
                  $urandom_range(1, 3), 1'b1, 1'b0);
            settle("random");
        end

        frame(40, 3, 40, 1, 1'b0, 1'b0);
        settle("overflow");

        frame(10, 0, 12, 1, 1'b0, 1'b1);
        settle("overlap");

        repeat (10) cycle(1'b1, 1'b0, 8'($urandom));
        #2;
        rst = 1'b0;
        #1;
        chkZero();
        expOvf = 0;
        expErr = 0;
        cycle(1'b0, 1'b0, 8'h00);
        rst = 1'b1;
        oData.delete(); oTime.delete(); oWr.delete(); oRd.delete(); oMiss.delete(); oDoneT.delete();
        frame(4, 2, 4, 2, 1'b1, 1'b0);
        settle("afterReset");

        for (int k = 0; k < 6; k++) begin
            frame($urandom_range(1, 40), $urandom_range(1, 4), $urandom_range(1, 45),
                  $urandom_range(1, 3), 1'b1, 1'b0);
            settle("randomOvf");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rw_window_responder.md
# rw_window_responder

Consumer end of the write/read window interface. Samples the `txWr` and `txRd` level windows produced by the window counter, captures `wrData` into a local buffer on every write-window cycle, and drains the buffer in order during the following read window. At the end of each frame it reports per-frame length statistics. It sits downstream of the window counter as the responder for its strobes.

## Interface
Parameters:
- `DATA_W`, default 8: width of the captured data word.
- `DEPTH`, default 32: buffer entries. Must be a power of 2 and at least 2.
- `ADDR_W`, default $clog2(DEPTH): pointer width. Derived; do not override.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  asynchronous, active-low reset. Asserting low clears all state immediately.
- `txWr`  in  1  write window, level; high means capture this cycle.
- `txRd`  in  1  read window, level; high means drain this cycle.
- `wrData`  in  DATA_W  data sampled on write cycles.
- `rdData`  out  DATA_W  drained word, registered.
- `rdValid`  out  1  `rdData` is valid this cycle.
- `frameDone`  out  1  one-cycle pulse at end of the read window.
- `frameWrLen`  out  ADDR_W+1  words accepted in the last frame.
- `frameRdLen`  out  ADDR_W+1  words drained in the last frame.
- `frameMiss`  out  ADDR_W+1  read cycles with an empty buffer in the last frame. Saturates at 2^(ADDR_W+1)-1.
- `overflow`  out  1  sticky; a write was dropped because the buffer was full.
- `windowErr`  out  1  sticky; `txWr` and `txRd` were high together.

## Operation
- FSM states, kept in the package enum:
  - IDLE
  - WRITE
  - READ
- State transitions:
  - IDLE → WRITE when `txWr`=1 and `txRd`=0.
  - IDLE → READ when `txRd`=1 and `txWr`=0.
  - WRITE → IDLE when `txWr`=0. Pointers and count are kept.
  - READ → IDLE when `txRd`=0. This is the frame end.
- Write cycle: any cycle in IDLE or WRITE with `txWr`=1 and `txRd`=0.
  - If count < DEPTH: store `wrData` at `wrPtr`, then increment `wrPtr` (wrapping mod DEPTH), count, and the frame write counter.
  - If count == DEPTH: drop the word and set `overflow`.
- Read cycle: any cycle in IDLE or READ with `txRd`=1 and `txWr`=0.
  - If count > 0: read `mem[rdPtr]`, increment `rdPtr` (wrapping), decrement count, and increment the frame read counter.
  - If count == 0: increment the miss counter (saturating).
- Frame end, on the cycle READ samples `txRd`=0:
  - Latch the frame counters into `frameWrLen`, `frameRdLen` and `frameMiss`.
  - Pulse `frameDone`.
  - Clear `wrPtr`, `rdPtr`, count and the frame counters. Undrained words are discarded.
- Simultaneous `txWr`=1 and `txRd`=1, in any state:
  - Set `windowErr`.
  - No write, no read.
  - Next state is IDLE. No frame end is generated, and the counters are kept.
- A write window that opens during READ (the overlap cycle) follows the simultaneous rule.
- A write window that opens after READ has ended starts a new frame.
- A read window with no prior write window: every read cycle is a miss; `frameRdLen`=0.
- `overflow` and `windowErr` clear only on reset.

## Timing
- Reset values, all asynchronous:
  - every output is 0;
  - state is IDLE;
  - pointers, count and frame counters are 0;
  - memory contents are not reset.
- Inputs are sampled at posedge. There is no input synchronizer: the inputs are in the same clock domain.
- Write latency: data sampled at edge N is readable by a read cycle at edge N+1 or later.
- Read latency: a read cycle at edge N gives `rdValid`=1 and `rdData` during cycle N+1. `rdValid` is deasserted on miss cycles.
- `frameDone` and the frame outputs update one cycle after the edge that samples `txRd` falling.
  - `frameDone` is high for exactly 1 cycle.
  - The frame outputs hold until the next frame end.
- Reset asserted mid-window: state is lost and the frame is discarded. After release, the first sampled `txWr` or `txRd` high starts fresh.
- Throughput: 1 write or 1 read per cycle. There is no backpressure.

## Structure
- `rw_window_pkg` contains:
  - the `state_t` enum (IDLE, WRITE, READ);
  - the default `DATA_W` and `DEPTH` constants;
  - the miss-counter saturation constant.
- Sub-module `rw_window_mem`: simple dual-port RAM with a synchronous write port and a registered read port. It is parameterized by DATA_W and DEPTH and produces `rdData`.
- Top level contains the FSM, pointers, count, frame counters and sticky flags.

## Test plan
- Nominal frame from the window counter (`txWr` high 20 cycles, idle 15, `txRd` high 25), `wrData` = 0..19:
  - 20 `rdValid` pulses carrying 0..19 in order;
  - `frameWrLen`=20, `frameRdLen`=20, `frameMiss`=5;
  - one `frameDone` pulse;
  - no sticky flags.
- Overflow with DEPTH=32: 40-cycle write window, then 40-cycle read window:
  - `overflow`=1, `frameWrLen`=32;
  - reads give the first 32 words;
  - `frameMiss`=8.
- Overlap: `txRd` rises 1 cycle before `txWr` falls, during a 10-word write:
  - `windowErr`=1;
  - the overlap cycle neither writes nor reads;
  - `frameWrLen`=9, and the read returns those 9 words.
- Read without write: 5-cycle `txRd` window after reset:
  - no `rdValid`;
  - `frameRdLen`=0, `frameMiss`=5, `frameDone` pulses once.
- Reset mid-frame: assert `rst` low after 10 writes and release it:
  - all outputs are 0 at once;
  - the next frame of 4 writes and 4 reads returns only the new data;
  - `frameWrLen`=4.
- Back-to-back frames:
  - frame 2 starts 1 cycle after frame 1's `frameDone`;
  - pointers restart at 0;
  - frame 2 data comes back in order, and the lengths are reported independently.
